// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// The result and overflow flag are held between conversions, so downstream
// display logic never sees a partial value.
module bin_to_bcd_seq #(
  parameter int unsigned IN_WIDTH = 14,
  parameter int unsigned DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int unsigned OUT_W = 4 * DIGITS;
  localparam int unsigned CAT_W = OUT_W + IN_WIDTH;
  localparam int unsigned CNT_W = $clog2(IN_WIDTH + 1);
  localparam int unsigned CMP_W = $clog2(10 ** DIGITS);
  localparam int unsigned EXT_W = (IN_WIDTH > CMP_W) ? IN_WIDTH : CMP_W;
  localparam logic [CMP_W-1:0] MAX_VAL = CMP_W'(10 ** DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [IN_WIDTH-1:0] shreg, shreg_nx;
  logic [OUT_W-1:0]    scratch, scratch_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                ovf_pending, ovf_pending_nx;
  logic [OUT_W-1:0]    bcd_nx;
  logic                busy_nx, done_nx, overflow_nx;

  logic [OUT_W-1:0]    adj;
  logic [CAT_W-1:0]    cat_sh;
  logic                last_step;

  // Add-3 correction: every nibble >= 5 gets +3 before the shift.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // Combined left shift; the top scratch bit falls off (only on overflow).
  assign cat_sh    = {adj, shreg} << 1;
  assign last_step = (cnt == CNT_W'(1));

  // Next-state and next-output logic.
  always_comb begin
    state_nx       = state;
    shreg_nx       = shreg;
    scratch_nx     = scratch;
    cnt_nx         = cnt;
    ovf_pending_nx = ovf_pending;
    bcd_nx         = bcd_out;
    overflow_nx    = overflow;
    done_nx        = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nx       = SHIFT;
          shreg_nx       = bin_in;
          scratch_nx     = '0;
          cnt_nx         = CNT_W'(IN_WIDTH);
          ovf_pending_nx = EXT_W'(bin_in) > EXT_W'(MAX_VAL);
        end
      end
      SHIFT: begin
        scratch_nx = cat_sh[CAT_W-1:IN_WIDTH];
        shreg_nx   = cat_sh[IN_WIDTH-1:0];
        cnt_nx     = cnt - CNT_W'(1);
        if (last_step) begin
          state_nx    = DONE;
          done_nx     = 1'b1;
          bcd_nx      = ovf_pending ? {DIGITS{4'h9}} : cat_sh[CAT_W-1:IN_WIDTH];
          overflow_nx = ovf_pending;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shreg       <= '0;
      scratch     <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      bcd_out     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nx;
      shreg       <= shreg_nx;
      scratch     <= scratch_nx;
      cnt         <= cnt_nx;
      ovf_pending <= ovf_pending_nx;
      bcd_out     <= bcd_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      overflow    <= overflow_nx;
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq with a scoreboard of expected results.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [13:0] bin_in;
  logic [15:0] bcd_out;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;
  logic [15:0] exp_held = 16'h0000;
  logic [16:0] sb[$];

  bin_to_bcd_seq #(.IN_WIDTH(14), .DIGITS(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bin_in   (bin_in),
    .bcd_out  (bcd_out),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Scoreboard: each done pulse pops and compares one expected result.
  always @(negedge clk) begin
    if (reset_n && done) begin
      logic [16:0] e;
      done_cnt++;
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_done observed=done expected=no_done");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("bcd_out", 32'(bcd_out), 32'(e[15:0]));
        check("overflow", 32'(overflow), 32'(e[16]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_conv(input logic [13:0] v, input logic [15:0] eb, input logic eo);
    sb.push_back({eo, eb});
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
    bin_in = 14'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    tick(13);
    check("done_early", 32'(done), 32'd0);
    check("hold_during_shift", 32'(bcd_out), 32'(exp_held));
    tick(1);
    check("done_latency", 32'(done), 32'd1);
    exp_held = eb;
    tick(1);
    check("done_fall", 32'(done), 32'd0);
    check("busy_fall", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc0;
    int v;
    reset_n = 1'b0;
    start   = 1'b0;
    bin_in  = '0;
    #1;
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Zero, typical, max and overflow values
    do_conv(14'd0,     16'h0000, 1'b0);
    do_conv(14'd1515,  16'h1515, 1'b0);
    do_conv(14'd165,   16'h0165, 1'b0);
    do_conv(14'd9999,  16'h9999, 1'b0);
    do_conv(14'd10000, 16'h9999, 1'b1);
    do_conv(14'd16383, 16'h9999, 1'b1);
    do_conv(14'd42,    16'h0042, 1'b0);

    // Busy lockout: start pulses during SHIFT and DONE are ignored
    dc0 = done_cnt;
    sb.push_back({1'b0, 16'h1234});
    @(negedge clk);
    bin_in = 14'd1234;
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
    bin_in = 14'd5678;
    tick(2);
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
    bin_in = 14'd777;
    tick(11);
    check("lock_done", 32'(done), 32'd1);
    start  = 1'b1;
    bin_in = 14'd5678;
    tick(1);
    start  = 1'b0;
    check("lock_busy_after_done", 32'(busy), 32'd0);
    exp_held = 16'h1234;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check("hold_idle", 32'(bcd_out), 32'(exp_held));
    end
    check("lock_one_done", 32'(done_cnt), 32'(dc0 + 1));

    // Back-to-back with start held high
    sb.push_back({1'b0, 16'h0001});
    sb.push_back({1'b0, 16'h0002});
    sb.push_back({1'b0, 16'h0003});
    @(negedge clk);
    bin_in = 14'd1;
    start  = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) bin_in = 14'(i + 2);
      else       start  = 1'b0;
      tick(13);
      check("b2b_done_early", 32'(done), 32'd0);
      tick(1);
      check("b2b_done", 32'(done), 32'd1);
      tick(1);
      check("b2b_done_fall", 32'(done), 32'd0);
      if (i < 2) tick(1);
    end
    exp_held = 16'h0003;

    // Model-checked values
    for (int i = 0; i < 4; i++) begin
      v = int'($urandom_range(9999, 0));
      do_conv(14'(v), to_bcd(v), 1'b0);
    end

    // Asynchronous reset in the middle of a conversion
    dc0 = done_cnt;
    @(negedge clk);
    bin_in = 14'd4321;
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
    tick(6);
    reset_n = 1'b0;
    #1;
    check("midrst_bcd", 32'(bcd_out), 32'h0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    exp_held = 16'h0000;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    tick(20);
    check("midrst_no_done", 32'(done_cnt), 32'(dc0));
    check("midrst_idle_bcd", 32'(bcd_out), 32'h0);
    do_conv(14'd4321, 16'h4321, 1'b0);

    tick(2);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
